// File: rtl/dff_force_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dff_force_pipe_pkg
// Description : Shared types and helpers for the dff_force_pipe register chain.
//               - force_e     : encoding of the force currently requested
//               - force_value : decodes s/r (and set/clear priority) to force_e
//               - parity_even : even-parity bit of a zero-extended word
// Revision    : 1.0 - initial release
// ============================================================================
package dff_force_pipe_pkg;

    // Widest word parity_even can fold; callers zero-extend into this width.
    localparam int c_PAR_MAX_W = 256;

    typedef enum logic [1:0] {
        FORCE_NONE = 2'd0,
        FORCE_SET  = 2'd1,
        FORCE_CLR  = 2'd2
    } force_e;

    // Clear applies when r is high and either clear has priority or s is low.
    function automatic force_e force_value(input logic s, input logic r,
                                           input logic clr_wins);
        force_e f;
        if (r && (clr_wins || !s)) begin
            f = FORCE_CLR;
        end else if (s || r) begin
            f = FORCE_SET;
        end else begin
            f = FORCE_NONE;
        end
        return f;
    endfunction

    // Bit that makes the total number of ones (word + bit) even.
    function automatic logic parity_even(input logic [c_PAR_MAX_W-1:0] v);
        return ^v;
    endfunction

endpackage : dff_force_pipe_pkg
`default_nettype wire

// File: rtl/dff_force_stage.sv
`default_nettype none
// ============================================================================
// Module      : dff_force_stage
// Description : One data/valid register of the elastic force pipe.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               i_accept        - stage may take a word this cycle
//               i_move          - the held word leaves this cycle
//               i_up_valid/data - word offered by the upstream side
//               i_force         - force active: valid data takes i_force_data
//               o_data/o_valid  - registered contents
// Revision    : 1.0 - initial release
// ============================================================================
module dff_force_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_accept,
    input  logic             i_move,
    input  logic             i_up_valid,
    input  logic [WIDTH-1:0] i_up_data,
    input  logic             i_force,
    input  logic [WIDTH-1:0] i_force_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid
);
    import dff_force_pipe_pkg::*;

    logic [WIDTH-1:0] r_data_q;
    logic [WIDTH-1:0] w_data_d;
    logic             r_valid_q;
    logic             w_valid_d;

    always_comb begin
        w_data_d  = r_data_q;
        w_valid_d = r_valid_q;
        if (i_force) begin
            // Only occupied stages are overwritten; occupancy never changes.
            if (r_valid_q) begin
                w_data_d = i_force_data;
            end
        end else if (i_accept && i_up_valid) begin
            w_data_d  = i_up_data;
            w_valid_d = 1'b1;
        end else if (i_move) begin
            // Word leaves with nothing behind it: data is kept, slot empties.
            w_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_q  <= '0;
            r_valid_q <= 1'b0;
        end else begin
            r_data_q  <= w_data_d;
            r_valid_q <= w_valid_d;
        end
    end

    assign o_data  = r_data_q;
    assign o_valid = r_valid_q;

endmodule : dff_force_stage
`default_nettype wire

// File: rtl/dff_force_pipe.sv
`default_nettype none
// ============================================================================
// Module      : dff_force_pipe
// Description : WIDTH-bit, DEPTH-stage elastic register chain with valid/ready
//               handshake and synchronous set/clear force that freezes flow.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               d, in_valid/in_ready - input word and handshake
//               s, r                - synchronous set / clear force
//               q, q_b              - last-stage data and its complement
//               out_valid/out_ready - output handshake
//               par_err             - stored parity mismatch on a valid output
//                                     (only with DFF_FORCE_PIPE_PARITY_EN)
// Config      : `define DFF_FORCE_PIPE_PARITY_EN adds a parity bit per stage.
// Revision    : 1.0 - initial release
// ============================================================================
module dff_force_pipe
    import dff_force_pipe_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 3,
    parameter int CLR_WINS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             s,
    input  logic             r,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_b,
    output logic             out_valid,
    input  logic             out_ready
`ifdef DFF_FORCE_PIPE_PARITY_EN
    ,
    output logic             par_err
`endif
);

`ifdef DFF_FORCE_PIPE_PARITY_EN
    localparam int c_PAR_W = 1;
`else
    localparam int c_PAR_W = 0;
`endif
    localparam int   c_SW       = WIDTH + c_PAR_W;
    localparam logic c_CLR_WINS = (CLR_WINS != 0);

    force_e           w_force_kind;
    logic             w_force;
    logic [WIDTH-1:0] w_force_word;
    logic [c_SW-1:0]  w_force_data;
    logic [c_SW-1:0]  w_in_word;

    logic [c_SW-1:0]  w_stage_data [DEPTH];
    logic [DEPTH-1:0] w_vld;
    logic [DEPTH-1:0] w_move;
    // w_accept[DEPTH] is the consumer's readiness feeding the last stage.
    logic [DEPTH:0]   w_accept;

    assign w_force_kind = force_value(s, r, c_CLR_WINS);
    assign w_force      = (w_force_kind != FORCE_NONE);
    assign w_force_word = (w_force_kind == FORCE_SET) ? '1 : '0;

`ifdef DFF_FORCE_PIPE_PARITY_EN
    logic [c_PAR_MAX_W-1:0] w_d_ext;
    logic [c_PAR_MAX_W-1:0] w_f_ext;
    logic [c_PAR_MAX_W-1:0] w_q_ext;

    always_comb begin
        w_d_ext = '0;
        w_f_ext = '0;
        w_q_ext = '0;
        w_d_ext[WIDTH-1:0] = d;
        w_f_ext[WIDTH-1:0] = w_force_word;
        w_q_ext[WIDTH-1:0] = w_stage_data[DEPTH-1][WIDTH-1:0];
    end

    assign w_in_word    = {parity_even(w_d_ext), d};
    assign w_force_data = {parity_even(w_f_ext), w_force_word};
    assign par_err      = w_vld[DEPTH-1] &
                          (parity_even(w_q_ext) ^ w_stage_data[DEPTH-1][WIDTH]);
`else
    assign w_in_word    = d;
    assign w_force_data = w_force_word;
`endif

    // Readiness ripples from the consumer back to stage 0 in one cycle, so a
    // full chain still accepts a word whenever the last stage is draining.
    always_comb begin
        w_accept        = '0;
        w_move          = '0;
        w_accept[DEPTH] = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            w_move[i]   = w_vld[i] & w_accept[i+1];
            w_accept[i] = ~w_vld[i] | w_move[i];
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic [c_SW-1:0] w_up_data;
            logic            w_up_valid;

            if (gi == 0) begin : g_first
                assign w_up_data  = w_in_word;
                assign w_up_valid = in_valid;
            end else begin : g_rest
                assign w_up_data  = w_stage_data[gi-1];
                assign w_up_valid = w_vld[gi-1];
            end

            dff_force_stage #(
                .WIDTH (c_SW)
            ) u_stage (
                .clk          (clk),
                .rst          (rst),
                .i_accept     (w_accept[gi] & ~w_force),
                .i_move       (w_move[gi] & ~w_force),
                .i_up_valid   (w_up_valid),
                .i_up_data    (w_up_data),
                .i_force      (w_force),
                .i_force_data (w_force_data),
                .o_data       (w_stage_data[gi]),
                .o_valid      (w_vld[gi])
            );
        end
    endgenerate

    assign in_ready  = w_accept[0] & ~w_force;
    assign q         = w_stage_data[DEPTH-1][WIDTH-1:0];
    assign q_b       = ~q;
    assign out_valid = w_vld[DEPTH-1];

endmodule : dff_force_pipe
`default_nettype wire
